hcount_source: RTL and testbench

- Message generator sitting directly upstream of the network's sink and router inputs.
- Emits a programmable sequence of counting messages on one outgoing 4-phase req/ack channel.
- Each message carries src, dst, dat and a redundancy field.
- Debounces the returning ack and reports protocol violations on an error channel; serves as the stimulus end for null-sink and router bring-up.

---
 rtl/hcount_source_pkg.sv | 45 ++++
 rtl/hack_debouncer.sv | 35 +++
 rtl/hcount_source.sv | 139 +++++++++++++
 tb/tb_hcount_source.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcount_source_pkg.sv
// rtl/hcount_source_pkg.sv - shared encodings, sizes and channel macros for the hcount network
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

// Redundancy sum: caller passes a working width W wide enough for all operands,
// every operand is zero-extended to W and the caller truncates to the redundancy width.
`ifndef NS_REDUN
`define NS_REDUN(W, s, d, t) (W'(s) + W'(d) + W'(t))
`endif

// Outgoing message channel port list; the caller supplies each full port name.
`ifndef NS_OUT_CHAN
`define NS_OUT_CHAN(src_n, dst_n, dat_n, red_n, req_n, ack_n, A, D, R) output logic [(A)-1:0] src_n, output logic [(A)-1:0] dst_n, output logic [(D)-1:0] dat_n, output logic [(R)-1:0] red_n, output logic req_n, input logic ack_n
`endif

// Sensitivity list for the asynchronous active-low reset flavour of the network.
`ifndef NS_ARST_N
`define NS_ARST_N(clk, rst) posedge clk or negedge rst
`endif

package hcount_source_pkg;

  typedef enum logic [2:0] {
    NS_SRC_INIT = 3'd0,
    NS_SRC_LOAD = 3'd1,
    NS_SRC_REQ  = 3'd2,
    NS_SRC_REL  = 3'd3,
    NS_SRC_DONE = 3'd4
  } ns_src_state_t;

  function automatic int ns_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hack_debouncer.sv
// rtl/hack_debouncer.sv - level debouncer for a req or ack input
module hack_debouncer
  import hcount_source_pkg::*;
#(
  parameter int ACK_CKS = `NS_REQ_CKS
) (
  input  logic gch_clk,
  input  logic gch_reset,
  input  logic sig_in,
  output logic ckd_out
);

  localparam int CW = (ACK_CKS > 1) ? $clog2(ACK_CKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACK_CKS - 1);

  logic [CW-1:0] cnt;

  // Accept a new level only after ACK_CKS consecutive differing samples; any agreeing sample restarts the count
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      ckd_out <= 1'b0;
      cnt     <= '0;
    end else if (sig_in != ckd_out) begin
      if (cnt == LAST) begin
        ckd_out <= sig_in;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/hcount_source.sv
// rtl/hcount_source.sv - counting message generator on a 4-phase req/ack channel
module hcount_source
  import hcount_source_pkg::*;
#(
  parameter int MY_LOCAL_ADDR = 0,
  parameter int DST_ADDR      = 0,
  parameter int ASZ           = `NS_ADDRESS_SIZE,
  parameter int DSZ           = `NS_DATA_SIZE,
  parameter int RSZ           = `NS_REDUN_SIZE,
  parameter int START_DATA    = 0,
  parameter int MSG_COUNT     = 4,
  parameter int ACK_CKS       = `NS_REQ_CKS
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req_out,
  input  logic           snd0_ack_in,
  output logic           done,
  output logic           err0_error,
  output logic [ASZ-1:0] err0_src,
  output logic [ASZ-1:0] err0_dst,
  output logic [DSZ-1:0] err0_dat
);

  localparam int MW = ns_max(ns_max(ASZ, DSZ), RSZ) + 2;
  localparam int SW = (MSG_COUNT > 0) ? $clog2(MSG_COUNT + 1) : 1;
  localparam logic [SW-1:0]  LAST_SENT = SW'((MSG_COUNT > 0) ? MSG_COUNT - 1 : 0);
  localparam logic [ASZ-1:0] SRC_C     = ASZ'(MY_LOCAL_ADDR);
  localparam logic [ASZ-1:0] DST_C     = ASZ'(DST_ADDR);
  localparam logic [DSZ-1:0] START_C   = DSZ'(START_DATA);

  ns_src_state_t  state;
  logic [DSZ-1:0] cur_dat;
  logic [SW-1:0]  sent;
  logic           ckd_ack;
  logic           ckd_prev;
  logic           ack_rise;
  logic [DSZ-1:0] load_dat;
  logic [RSZ-1:0] load_red;

  assign err0_src = SRC_C;
  assign ack_rise = ckd_ack & ~ckd_prev;

  hack_debouncer #(
    .ACK_CKS (ACK_CKS)
  ) u_ack_deb (
    .gch_clk   (gch_clk),
    .gch_reset (gch_reset),
    .sig_in    (snd0_ack_in),
    .ckd_out   (ckd_ack)
  );

  // Data value and redundancy for the message about to enter LOAD (next count when leaving REL)
  always_comb begin
    load_dat = cur_dat;
    if (state == NS_SRC_REL) begin
      load_dat = cur_dat + DSZ'(1);
    end
    load_red = RSZ'(`NS_REDUN(MW, SRC_C, DST_C, load_dat));
  end

  // Handshake sequencer: fields are registered on entry to LOAD so they settle a clock before req
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      state        <= NS_SRC_INIT;
      gch_ready    <= 1'b0;
      snd0_req_out <= 1'b0;
      done         <= 1'b0;
      snd0_src     <= '0;
      snd0_dst     <= '0;
      snd0_dat     <= '0;
      snd0_red     <= '0;
      cur_dat      <= START_C;
      sent         <= '0;
      ckd_prev     <= 1'b0;
      err0_error   <= 1'b0;
      err0_dst     <= '0;
      err0_dat     <= '0;
    end else begin
      ckd_prev <= ckd_ack;
      if (ack_rise && !err0_error &&
          (state == NS_SRC_INIT || state == NS_SRC_LOAD || state == NS_SRC_DONE)) begin
        err0_error <= 1'b1;
        err0_dst   <= snd0_dst;
        err0_dat   <= snd0_dat;
      end
      case (state)
        NS_SRC_INIT: begin
          gch_ready <= 1'b1;
          snd0_src  <= SRC_C;
          snd0_dst  <= DST_C;
          snd0_dat  <= load_dat;
          snd0_red  <= load_red;
          state     <= NS_SRC_LOAD;
        end
        NS_SRC_LOAD: begin
          snd0_req_out <= 1'b1;
          state        <= NS_SRC_REQ;
        end
        NS_SRC_REQ: begin
          if (ckd_ack) begin
            snd0_req_out <= 1'b0;
            state        <= NS_SRC_REL;
          end
        end
        NS_SRC_REL: begin
          if (!ckd_ack) begin
            sent <= sent + SW'(1);
            if (MSG_COUNT != 0 && sent == LAST_SENT) begin
              done  <= 1'b1;
              state <= NS_SRC_DONE;
            end else begin
              cur_dat  <= load_dat;
              snd0_src <= SRC_C;
              snd0_dst <= DST_C;
              snd0_dat <= load_dat;
              snd0_red <= load_red;
              state    <= NS_SRC_LOAD;
            end
          end
        end
        NS_SRC_DONE: begin
          snd0_req_out <= 1'b0;
          done         <= 1'b1;
        end
        default: begin
          snd0_req_out <= 1'b0;
          state        <= NS_SRC_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcount_source.sv
// tb/tb_hcount_source.sv - directed self-checking bench for hcount_source
module tb_hcount_source;

  logic clk;
  int   errors;
  int   checks;

  // instance a: START 14, MSG_COUNT 3, ACK_CKS 2
  logic a_rst, a_ready, a_req, a_ack, a_done, a_err;
  logic [5:0] a_src, a_dst, a_esrc, a_edst;
  logic [3:0] a_dat, a_red, a_edat;
  // instance b: START 13, MSG_COUNT 0, ACK_CKS 3
  logic b_rst, b_ready, b_req, b_ack, b_done, b_err;
  logic [5:0] b_src, b_dst, b_esrc, b_edst;
  logic [3:0] b_dat, b_red, b_edat;
  // instance c: START 7, MSG_COUNT 4, ACK_CKS 1
  logic c_rst, c_ready, c_req, c_ack, c_done, c_err;
  logic [5:0] c_src, c_dst, c_esrc, c_edst;
  logic [3:0] c_dat, c_red, c_edat;

  hcount_source #(.MY_LOCAL_ADDR(5), .DST_ADDR(9), .ASZ(6), .DSZ(4), .RSZ(4),
                  .START_DATA(14), .MSG_COUNT(3), .ACK_CKS(2)) u_a (
    .gch_clk(clk), .gch_reset(a_rst), .gch_ready(a_ready),
    .snd0_src(a_src), .snd0_dst(a_dst), .snd0_dat(a_dat), .snd0_red(a_red),
    .snd0_req_out(a_req), .snd0_ack_in(a_ack), .done(a_done),
    .err0_error(a_err), .err0_src(a_esrc), .err0_dst(a_edst), .err0_dat(a_edat));

  hcount_source #(.MY_LOCAL_ADDR(5), .DST_ADDR(9), .ASZ(6), .DSZ(4), .RSZ(4),
                  .START_DATA(13), .MSG_COUNT(0), .ACK_CKS(3)) u_b (
    .gch_clk(clk), .gch_reset(b_rst), .gch_ready(b_ready),
    .snd0_src(b_src), .snd0_dst(b_dst), .snd0_dat(b_dat), .snd0_red(b_red),
    .snd0_req_out(b_req), .snd0_ack_in(b_ack), .done(b_done),
    .err0_error(b_err), .err0_src(b_esrc), .err0_dst(b_edst), .err0_dat(b_edat));

  hcount_source #(.MY_LOCAL_ADDR(5), .DST_ADDR(9), .ASZ(6), .DSZ(4), .RSZ(4),
                  .START_DATA(7), .MSG_COUNT(4), .ACK_CKS(1)) u_c (
    .gch_clk(clk), .gch_reset(c_rst), .gch_ready(c_ready),
    .snd0_src(c_src), .snd0_dst(c_dst), .snd0_dat(c_dat), .snd0_red(c_red),
    .snd0_req_out(c_req), .snd0_ack_in(c_ack), .done(c_done),
    .err0_error(c_err), .err0_src(c_esrc), .err0_dst(c_edst), .err0_dat(c_edat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    checks++;
    if ({a_ready, a_req, a_done, a_err, a_dat} !== 8'h00) begin
      errors++; $display("FAIL reset_a: got %b expected 00000000", {a_ready, a_req, a_done, a_err, a_dat});
    end
    checks++;
    if ({b_ready, b_req, b_done, b_err, b_dat} !== 8'h00) begin
      errors++; $display("FAIL reset_b: got %b expected 00000000", {b_ready, b_req, b_done, b_err, b_dat});
    end
    checks++;
    if ({c_ready, c_req, c_done, c_err, c_dat} !== 8'h00) begin
      errors++; $display("FAIL reset_c: got %b expected 00000000", {c_ready, c_req, c_done, c_err, c_dat});
    end
    checks++;
    if (a_esrc !== 6'd5) begin
      errors++; $display("FAIL reset_err_src: got %0d expected 5", a_esrc);
    end
    a_rst = 1'b1;
    b_rst = 1'b1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b expected 0", a_ready);
    end
    @(negedge clk);
    checks++;
    if ({a_ready, a_req, a_dat, a_red} !== {1'b1, 1'b0, 4'd14, 4'd12}) begin
      errors++; $display("FAIL first_load: got ready=%b req=%b dat=%0d red=%0d expected 1 0 14 12",
                         a_ready, a_req, a_dat, a_red);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ed [3];
    logic [3:0] er [3];
    logic [3:0] load_dat;
    int n;
    int hi;
    int bad;
    ed = '{4'd14, 4'd15, 4'd0};
    er = '{4'd12, 4'd13, 4'd14};
    for (int m = 0; m < 3; m++) begin
      n = 0;
      load_dat = a_dat;
      while (a_req !== 1'b1 && n < 50) begin
        load_dat = a_dat;
        @(negedge clk);
        n++;
      end
      checks++;
      if (a_req !== 1'b1) begin
        errors++; $display("FAIL basic_req_wait msg %0d: got req=%b expected 1", m, a_req);
      end
      checks++;
      if (a_dat !== ed[m] || a_red !== er[m]) begin
        errors++; $display("FAIL basic_fields msg %0d: got dat=%0d red=%0d expected %0d %0d",
                           m, a_dat, a_red, ed[m], er[m]);
      end
      checks++;
      if (a_done !== 1'b0) begin
        errors++; $display("FAIL basic_done_early msg %0d: got %b expected 0", m, a_done);
      end
      bad = 0;
      if (a_src !== 6'd5 || a_dst !== 6'd9 || a_dat !== load_dat) bad++;
      @(negedge clk);
      a_ack = 1'b1;
      hi = 0;
      while (a_req === 1'b1 && hi < 20) begin
        if (a_src !== 6'd5 || a_dst !== 6'd9 || a_dat !== load_dat) bad++;
        @(negedge clk);
        hi++;
      end
      a_ack = 1'b0;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL stable_fields msg %0d: got %0d unstable clocks expected 0", m, bad);
      end
      checks++;
      if (hi != 3) begin
        errors++; $display("FAIL req_hold_after_ack msg %0d: got %0d clocks expected 3", m, hi);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_req !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done=%b req=%b expected 1 0", a_done, a_req);
    end
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_req !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL no_fourth_req: got %0d req clocks expected 0", n);
    end
    checks++;
    if (a_err !== 1'b0) begin
      errors++; $display("FAIL basic_no_error: got %b expected 0", a_err);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    #2 a_rst = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_done, a_req} !== 3'b000) begin
      errors++; $display("FAIL async_reset_done: got ready/done/req=%b expected 000", {a_ready, a_done, a_req});
    end
    @(negedge clk);
    a_rst = 1'b1;
    n = 0;
    while (a_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_req !== 1'b1 || a_dat !== 4'd14) begin
      errors++; $display("FAIL restart_msg: got req=%b dat=%0d expected 1 14", a_req, a_dat);
    end
    #2 a_rst = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_done, a_req} !== 3'b000) begin
      errors++; $display("FAIL async_reset_req: got ready/done/req=%b expected 000", {a_ready, a_done, a_req});
    end
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_req, a_dat} !== {1'b1, 1'b0, 4'd14}) begin
      errors++; $display("FAIL after_reset_load: got ready=%b req=%b dat=%0d expected 1 0 14", a_ready, a_req, a_dat);
    end
    @(negedge clk);
    checks++;
    if (a_req !== 1'b1 || a_dat !== 4'd14) begin
      errors++; $display("FAIL after_reset_req: got req=%b dat=%0d expected 1 14", a_req, a_dat);
    end
  endtask

  task automatic test_glitch();
    int n;
    int drops;
    int hi;
    n = 0;
    while (b_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b_req !== 1'b1 || b_dat !== 4'd13) begin
      errors++; $display("FAIL glitch_start: got req=%b dat=%0d expected 1 13", b_req, b_dat);
    end
    b_ack = 1'b1;
    repeat (2) @(negedge clk);
    b_ack = 1'b0;
    drops = 0;
    repeat (4) begin
      if (b_req !== 1'b1) drops++;
      @(negedge clk);
    end
    checks++;
    if (drops != 0) begin
      errors++; $display("FAIL glitch_req_held: got %0d low clocks expected 0", drops);
    end
    b_ack = 1'b1;
    hi = 0;
    while (b_req === 1'b1 && hi < 20) begin
      @(negedge clk);
      hi++;
    end
    b_ack = 1'b0;
    checks++;
    if (hi != 4) begin
      errors++; $display("FAIL glitch_full_ack: got %0d req clocks expected 4", hi);
    end
    checks++;
    if (b_err !== 1'b0) begin
      errors++; $display("FAIL glitch_no_error: got %b expected 0", b_err);
    end
  endtask

  task automatic test_msgcount0();
    logic [3:0] exp_dat;
    logic [3:0] exp_red;
    int n;
    exp_dat = 4'd14;
    for (int h = 0; h < 20; h++) begin
      exp_red = exp_dat + 4'd14;
      n = 0;
      while (b_req !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (b_req !== 1'b1 || b_dat !== exp_dat || b_red !== exp_red) begin
        errors++; $display("FAIL forever_msg %0d: got req=%b dat=%0d red=%0d expected 1 %0d %0d",
                           h, b_req, b_dat, b_red, exp_dat, exp_red);
      end
      b_ack = 1'b1;
      n = 0;
      while (b_req === 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      b_ack = 1'b0;
      checks++;
      if (b_req !== 1'b0) begin
        errors++; $display("FAIL forever_release %0d: got req=%b expected 0", h, b_req);
      end
      checks++;
      if (b_done !== 1'b0) begin
        errors++; $display("FAIL forever_done %0d: got %b expected 0", h, b_done);
      end
      exp_dat = exp_dat + 4'd1;
    end
  endtask

  task automatic test_spurious();
    int n;
    c_ack = 1'b1;
    @(negedge clk);
    c_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({c_err, c_esrc, c_edst, c_edat} !== {1'b1, 6'd5, 6'd9, 4'd7}) begin
      errors++; $display("FAIL spurious_capture: got err=%b src=%0d dst=%0d dat=%0d expected 1 5 9 7",
                         c_err, c_esrc, c_edst, c_edat);
    end
    repeat (10) @(negedge clk);
    c_ack = 1'b0;
    n = 0;
    while (c_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (c_req !== 1'b1 || c_dat !== 4'd8) begin
      errors++; $display("FAIL spurious_continue: got req=%b dat=%0d expected 1 8", c_req, c_dat);
    end
    checks++;
    if (c_err !== 1'b1 || c_edat !== 4'd7) begin
      errors++; $display("FAIL spurious_sticky: got err=%b dat=%0d expected 1 7", c_err, c_edat);
    end
    #2 c_rst = 1'b0;
    #1;
    checks++;
    if (c_err !== 1'b0 || c_req !== 1'b0) begin
      errors++; $display("FAIL spurious_reset: got err=%b req=%b expected 0 0", c_err, c_req);
    end
    @(negedge clk);
    c_rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (c_err !== 1'b0) begin
      errors++; $display("FAIL spurious_clean_restart: got %b expected 0", c_err);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_ack = 1'b0; b_ack = 1'b0; c_ack = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_async_reset();
    test_glitch();
    test_msgcount0();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
